// File: rtl/hwpe_ctrl_target_if.sv
// Request/response channel between the AXI-to-TCDM bridge (master) and the HWPE control target (slave).
interface hwpe_ctrl_target_if #(
    parameter int AddrWidth = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic [AddrWidth-1:0] req_addr;
    logic                 req_write;
    logic [31:0]          req_wdata;
    logic [3:0]           req_be;
    logic                 rsp_valid;
    logic [31:0]          rsp_rdata;

    modport master (
        output req_valid, req_addr, req_write, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_write, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/hwpe_ctrl_target.sv
// HWPE control-port responder: job register file, NrContexts-deep job queue, dispatch FSM
// and a one-cycle completion event towards every cluster core.
module hwpe_ctrl_target #(
    parameter int NrCores    = 8,
    parameter int NumJobRegs = 8,
    parameter int NrContexts = 2,
    parameter int AddrWidth  = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    hwpe_ctrl_target_if.slave       bus,
    output logic                    job_start_o,
    output logic [NumJobRegs*32-1:0] job_regs_o,
    output logic [7:0]              job_id_o,
    input  logic                    engine_busy_i,
    input  logic                    engine_done_i,
    output logic                    clear_o,
    output logic [NrCores-1:0]      evt_o
);

    localparam int              CntW    = $clog2(NrContexts + 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(NrContexts);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StStart   = 2'd1;
    localparam logic [1:0] StRunning = 2'd2;

    localparam logic [5:0] WTrigger  = 6'd0;
    localparam logic [5:0] WAcquire  = 6'd1;
    localparam logic [5:0] WFinished = 6'd2;
    localparam logic [5:0] WStatus   = 6'd3;
    localparam logic [5:0] WRunId    = 6'd4;
    localparam logic [5:0] WSoftClr  = 6'd5;

    logic [1:0]                              state_q, state_d;
    logic [CntW-1:0]                         count_q, count_d;
    logic [NrContexts-1:0][NumJobRegs*32-1:0] queue_regs_q;
    logic [NrContexts-1:0][7:0]              queue_id_q;
    logic [NumJobRegs-1:0][31:0]             staging_q;
    logic [7:0]                              id_q;
    logic                                    acquired_q;
    logic [31:0]                             finished_q;
    logic                                    rsp_valid_q;
    logic [31:0]                             rsp_rdata_q, rdata_d;
    logic                                    clear_q;
    logic [NrCores-1:0]                      evt_q;

    logic [5:0]      word;
    logic            rd_req, wr_req, be_any, queue_empty, acquire_ok;
    logic            do_acquire, do_trigger, do_clear, do_pop;
    logic [CntW-1:0] push_idx;
    logic [7:0]      head_id;
    logic            unused_addr;

    assign word        = bus.req_addr[7:2];
    assign unused_addr = ^{bus.req_addr[AddrWidth-1:8], bus.req_addr[1:0]};
    assign rd_req      = bus.req_valid & ~bus.req_write;
    assign wr_req      = bus.req_valid & bus.req_write;
    assign be_any      = |bus.req_be;
    assign queue_empty = (count_q == '0);

    // An outstanding acquisition always owns a free slot, so it keeps succeeding with the same ID.
    assign acquire_ok = acquired_q | (count_q != FullCnt);
    assign do_acquire = rd_req & (word == WAcquire) & acquire_ok;
    assign do_trigger = wr_req & (word == WTrigger) & be_any & acquired_q;
    assign do_clear   = wr_req & (word == WSoftClr) & be_any;
    assign do_pop     = (state_q == StRunning) & engine_done_i & ~do_clear;
    assign push_idx   = count_q - CntW'(do_pop);
    assign head_id    = queue_empty ? 8'd0 : queue_id_q[0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (!queue_empty && !engine_busy_i) state_d = StStart;
            StStart:   state_d = StRunning;
            StRunning: if (engine_done_i) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        if (do_clear) state_d = StIdle;
    end

    always_comb begin
        count_d = count_q;
        if (do_clear)                     count_d = '0;
        else if (do_trigger && !do_pop)   count_d = count_q + CntW'(1);
        else if (!do_trigger && do_pop)   count_d = count_q - CntW'(1);
    end

    always_comb begin
        rdata_d = '0;
        if (rd_req) begin
            case (word)
                WAcquire:  rdata_d = acquire_ok ? {24'd0, id_q} : 32'hFFFF_FFFF;
                WFinished: rdata_d = finished_q;
                WStatus:   rdata_d = {22'd0, 8'(count_q), count_q == FullCnt, state_q != StIdle};
                WRunId:    rdata_d = {24'd0, head_id};
                default: begin
                    for (int i = 0; i < NumJobRegs; i++)
                        if (word == 6'(16 + i)) rdata_d = staging_q[i];
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            count_q     <= '0;
            id_q        <= '0;
            acquired_q  <= 1'b0;
            finished_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            clear_q     <= 1'b0;
            evt_q       <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rsp_valid_q <= bus.req_valid;
            rsp_rdata_q <= rdata_d;
            clear_q     <= do_clear;
            evt_q       <= {NrCores{do_pop}};
            if (do_trigger) id_q <= id_q + 8'd1;
            if (do_clear || do_trigger) acquired_q <= 1'b0;
            else if (do_acquire)        acquired_q <= 1'b1;
            if (wr_req && word == WFinished) finished_q <= '0;
            else if (do_pop)                 finished_q <= finished_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            staging_q <= '0;
        end else begin
            for (int i = 0; i < NumJobRegs; i++)
                if (wr_req && word == 6'(16 + i))
                    for (int b = 0; b < 4; b++)
                        if (bus.req_be[b]) staging_q[i][8*b +: 8] <= bus.req_wdata[8*b +: 8];
        end
    end

    // Head lives in slot 0; a push in the same cycle as a pop lands one slot lower than count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            queue_regs_q <= '0;
            queue_id_q   <= '0;
        end else begin
            if (do_pop) begin
                for (int k = 0; k < NrContexts - 1; k++) begin
                    queue_regs_q[k] <= queue_regs_q[k+1];
                    queue_id_q[k]   <= queue_id_q[k+1];
                end
            end
            if (do_trigger) begin
                for (int k = 0; k < NrContexts; k++) begin
                    if (push_idx == CntW'(k)) begin
                        queue_regs_q[k] <= staging_q;
                        queue_id_q[k]   <= id_q;
                    end
                end
            end
        end
    end

    assign bus.req_ready = 1'b1;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign job_start_o   = (state_q == StStart);
    assign job_regs_o    = queue_empty ? '0 : queue_regs_q[0];
    assign job_id_o      = head_id;
    assign clear_o       = clear_q;
    assign evt_o         = evt_q;

endmodule
